// File: rtl/garage_input_conditioner_if.sv
// Signal bundle between the raw garage inputs and the conditioned controller inputs.
// The slave side is the conditioner; the master side drives raws and observes results.
interface garage_input_conditioner_if;
  logic Btn_Raw;
  logic Up_Sw_Raw;
  logic Dn_Sw_Raw;
  logic Activate;
  logic UP_Max;
  logic DN_Max;
  logic Sw_Fault;

  modport slave (
    input  Btn_Raw, Up_Sw_Raw, Dn_Sw_Raw,
    output Activate, UP_Max, DN_Max, Sw_Fault
  );

  modport master (
    output Btn_Raw, Up_Sw_Raw, Dn_Sw_Raw,
    input  Activate, UP_Max, DN_Max, Sw_Fault
  );
endinterface

// File: rtl/garage_input_conditioner.sv
// Synchronises and debounces the push-button and both door limit switches, then turns
// each accepted button press into a single-cycle Activate pulse for the door controller.
module garage_input_conditioner #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 5
) (
  input logic                    CLK,
  input logic                    RST,
  garage_input_conditioner_if.slave bus
);

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } btn_state_t;

  localparam int BTN = 0;
  localparam int UP  = 1;
  localparam int DN  = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [2:0]       raw;
  logic [2:0]       sync_q;
  logic [2:0]       stable_q;
  logic [CNT_W-1:0] cnt_q [3];

  btn_state_t state_q;
  btn_state_t state_d;
  logic       activate_d;
  logic       activate_q;
  logic       fault_level;
  logic       fault_q;

  assign raw = {bus.Dn_Sw_Raw, bus.Up_Sw_Raw, bus.Btn_Raw};

  // The debounce registers form the second synchroniser stage, so counting starts
  // one edge after capture and an accepted level appears DB_CYCLES edges later.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q   <= '0;
      stable_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync_q <= raw;
      for (int i = 0; i < 3; i++) begin
        if (sync_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          stable_q[i] <= sync_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign fault_level = stable_q[UP] & stable_q[DN];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= RELEASED;
      activate_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      activate_q <= activate_d;
      fault_q    <= fault_level;
    end
  end

  // A press during a limit fault still moves to PRESSED, so it is swallowed rather than deferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RELEASED: if (stable_q[BTN])  state_d = PRESSED;
      PRESSED:  if (!stable_q[BTN]) state_d = RELEASED;
      default:  state_d = RELEASED;
    endcase
  end

  always_comb begin
    activate_d = 1'b0;
    if (state_q == RELEASED && stable_q[BTN] && !fault_level) activate_d = 1'b1;
  end

  assign bus.Activate = activate_q;
  assign bus.UP_Max   = stable_q[UP];
  assign bus.DN_Max   = stable_q[DN];
  assign bus.Sw_Fault = fault_q;

endmodule

// File: tb/tb_garage_input_conditioner.sv
// Directed bench for garage_input_conditioner with DB_CYCLES=4: press, bounce, limit,
// fault-lockout and reset scenarios with hand-computed edge counts.
module tb_garage_input_conditioner;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   passCount  = 0;
  int   failCount  = 0;
  int   checkCount = 0;

  garage_input_conditioner_if bus ();

  garage_input_conditioner #(.DB_CYCLES(4), .CNT_W(5)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic btn, input logic up, input logic dn);
    bus.Btn_Raw   = btn;
    bus.Up_Sw_Raw = up;
    bus.Dn_Sw_Raw = dn;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic countPulses(input int n, output int pulses, output int upSeen);
    pulses = 0;
    upSeen = 0;
    repeat (n) begin
      tick(1);
      pulses += int'(bus.Activate);
      upSeen += int'(bus.UP_Max);
    end
  endtask

  // Raw level was just driven: no pulse for five edges, high after edge 6, low after edge 7.
  task automatic expectPulse(input string tag);
    int pulses, upSeen;
    countPulses(5, pulses, upSeen);
    checkOutput({tag, "_early"}, pulses, 0);
    tick(1);
    checkOutput({tag, "_edge6"}, int'(bus.Activate), 1);
    tick(1);
    checkOutput({tag, "_edge7"}, int'(bus.Activate), 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_act"},   int'(bus.Activate), 0);
    checkOutput({tag, "_up"},    int'(bus.UP_Max),   0);
    checkOutput({tag, "_dn"},    int'(bus.DN_Max),   0);
    checkOutput({tag, "_fault"}, int'(bus.Sw_Fault), 0);
  endtask

  initial begin
    int   pulses, upSeen;
    logic bounce [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    applyStimulus(1'b0, 1'b0, 1'b0);
    #2;
    checkAllZero("por");
    tick(2);
    RST = 1'b1;
    tick(4);

    $display("[TB] clean press");
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectPulse("press1");
    countPulses(13, pulses, upSeen);
    checkOutput("press1_hold", pulses, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(8);
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectPulse("press2");
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(8);

    $display("[TB] bounce rejection");
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(bounce[i], 1'b0, 1'b0);
      tick(1);
      pulses += int'(bus.Activate);
    end
    checkOutput("bounce_burst", pulses, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectPulse("bounce_steady");
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(8);

    $display("[TB] limit debounce");
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    countPulses(8, pulses, upSeen);
    checkOutput("up_short", upSeen, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(4);
    checkOutput("up_rise_e4", int'(bus.UP_Max), 0);
    tick(1);
    checkOutput("up_rise_e5", int'(bus.UP_Max), 1);
    tick(3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(4);
    checkOutput("up_fall_e4", int'(bus.UP_Max), 1);
    tick(1);
    checkOutput("up_fall_e5", int'(bus.UP_Max), 0);
    tick(4);

    $display("[TB] fault lockout");
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick(5);
    checkOutput("both_up", int'(bus.UP_Max), 1);
    checkOutput("both_dn", int'(bus.DN_Max), 1);
    checkOutput("both_fault_e5", int'(bus.Sw_Fault), 0);
    tick(1);
    checkOutput("both_fault_e6", int'(bus.Sw_Fault), 1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    countPulses(10, pulses, upSeen);
    checkOutput("fault_press", pulses, 0);
    checkOutput("fault_held", int'(bus.Sw_Fault), 1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    countPulses(10, pulses, upSeen);
    checkOutput("fault_drop_dn", pulses, 0);
    checkOutput("fault_cleared", int'(bus.Sw_Fault), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(8);
    applyStimulus(1'b1, 1'b1, 1'b0);
    expectPulse("fault_repress");
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(10);

    $display("[TB] reset mid-count");
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(3);
    RST = 1'b0;
    #1;
    checkAllZero("midrst");
    countPulses(4, pulses, upSeen);
    checkOutput("midrst_window", pulses, 0);
    RST = 1'b1;
    expectPulse("midrst_after");
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(8);

    $display("[TB] reset with all raws high");
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick(10);
    RST = 1'b0;
    #1;
    checkAllZero("allhigh_rst");
    tick(2);
    RST = 1'b1;
    tick(4);
    checkOutput("allhigh_e4_up", int'(bus.UP_Max), 0);
    tick(1);
    checkOutput("allhigh_e5_up", int'(bus.UP_Max), 1);
    checkOutput("allhigh_e5_dn", int'(bus.DN_Max), 1);
    checkOutput("allhigh_e5_fault", int'(bus.Sw_Fault), 0);
    tick(1);
    checkOutput("allhigh_e6_fault", int'(bus.Sw_Fault), 1);
    checkOutput("allhigh_e6_act", int'(bus.Activate), 0);
    countPulses(4, pulses, upSeen);
    checkOutput("allhigh_nopulse", pulses, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
